// File: rtl/mips_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op select, FSM states, word width.
// Pure declarations; no logic, no latency, no flow control.
// Imported by mult_div_unit and md_datapath_step.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    // op[1] selects divide, op[0] selects unsigned
    function automatic logic op_is_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/md_datapath_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Purely combinational, zero latency.
// No flow control; the caller decides when to register the result.
module md_datapath_step
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_hi_nxt,
    output logic [WIDTH-1:0] acc_lo_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        // multiply: acc_hi is the partial product, acc_lo the multiplier being consumed LSB-first
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        diff    = shifted[WIDTH-1:0] - operand;

        acc_hi_nxt = sum[WIDTH:1];
        acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (fits) begin
                acc_hi_nxt = diff;
                acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_nxt = shifted[WIDTH-1:0];
                acc_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Latency: start at edge E0, HI/LO written and done pulsed at edge E0+33; busy high 33 cycles.
// No queueing: start/mthi/mtlo while busy are dropped; cancel aborts without touching HI/LO.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             div_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] acc_hi_step, acc_lo_step;

    // start-time operand conditioning
    md_op_e           op_in;
    logic             in_div, in_signed, div_zero;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // FIX-time sign correction
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   hi_res, lo_res;

    logic start_ok, fix_commit, idle_write;

    assign start_ok   = (state == IDLE) && start;
    assign fix_commit = (state == FIX) && !cancel;
    assign idle_write = (state == IDLE) && !start;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (cancel)                 state_nxt = IDLE;
                else if (count == CNT_LAST) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // ---------------- counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (start_ok) begin
            count <= '0;
        end else if (state == RUN) begin
            count <= count + 1'b1;
        end
    end

    // ---------------- operand capture ----------------
    always_comb begin
        op_in     = md_op_e'(op);
        in_div    = op_is_div(op_in);
        in_signed = op_is_signed(op_in);
        div_zero  = in_div && (rt_data == '0);
        a_neg     = in_signed && rs_data[WIDTH-1];
        b_neg     = in_signed && rt_data[WIDTH-1];
        a_mag     = a_neg ? (~rs_data + 1'b1) : rs_data;
        b_mag     = b_neg ? (~rt_data + 1'b1) : rt_data;
    end

    md_datapath_step #(.WIDTH(WIDTH)) u_step (
        .is_div     (div_q),
        .acc_hi     (acc_hi),
        .acc_lo     (acc_lo),
        .operand    (operand_q),
        .acc_hi_nxt (acc_hi_step),
        .acc_lo_nxt (acc_lo_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            operand_q <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
        end else if (start_ok) begin
            div_q   <= in_div;
            // divide-by-zero runs unsigned on the raw dividend so the
            // restoring loop naturally yields q=all-ones, r=rs_data
            neg_q_q <= !div_zero && (a_neg ^ b_neg);
            neg_r_q <= !div_zero && a_neg;
            acc_hi  <= '0;
            if (in_div) begin
                acc_lo    <= div_zero ? rs_data : a_mag;
                operand_q <= b_mag;
            end else begin
                acc_lo    <= b_mag;
                operand_q <= a_mag;
            end
        end else if (state == RUN) begin
            acc_hi <= acc_hi_step;
            acc_lo <= acc_lo_step;
        end
    end

    // ---------------- result fix-up ----------------
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q_q ? (~prod + 1'b1) : prod;
        quo_fix  = neg_q_q ? (~acc_lo + 1'b1) : acc_lo;
        rem_fix  = neg_r_q ? (~acc_hi + 1'b1) : acc_hi;
        if (div_q) begin
            hi_res = rem_fix;
            lo_res = quo_fix;
        end else begin
            hi_res = prod_fix[2*WIDTH-1:WIDTH];
            lo_res = prod_fix[WIDTH-1:0];
        end
    end

    // ---------------- HI/LO and done ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= fix_commit;
            if (fix_commit) begin
                hi <= hi_res;
                lo <= lo_res;
            end else if (idle_write) begin
                if (mthi) hi <= wr_data;
                if (mtlo) lo <= wr_data;
            end
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit for the EX stage, directly downstream of the register file.
- Consumes the two register read operands (rs, rt) and executes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds the architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write.
- Asserts busy so the hazard logic stalls dependent instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  WIDTH  operand A (multiplicand / dividend), from register file read port 1.
- rt_data  input  WIDTH  operand B (multiplier / divisor), from register file read port 2.
- cancel  input  1  pipeline flush; aborts an in-flight operation.
- mthi  input  1  write wr_data to HI.
- mtlo  input  1  write wr_data to LO.
- wr_data  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO update with a result.
- hi  output  WIDTH  HI register, driven directly by the register.
- lo  output  WIDTH  LO register, driven directly by the register.

Behaviour:
- Reset:
  - Single clock clk; reset rst is synchronous, active-high.
  - rst forces state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
  - rst has priority over every other input, including mid-operation.
- States: IDLE, RUN, FIX. busy = (state != IDLE), combinational from state.
- IDLE, start=1 at an edge:
  - Latch op and the signed flag.
  - Latch magnitudes |A| and |B|; abs is applied for signed ops only.
  - Latch result sign: product sign = A[31]^B[31]; quotient sign same; remainder sign = A[31].
  - Go to RUN with count=0.
- RUN:
  - One radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - count increments each cycle; after the step with count=31, go to FIX.
- FIX:
  - Apply sign correction (two's-complement negate) where required.
  - Multiply: hi=product[63:32], lo=product[31:0].
  - Divide: lo=quotient, hi=remainder.
  - done=1 for this one edge's output cycle only. Go to IDLE.
- Latency: start sampled at edge E0; HI/LO valid and done=1 after edge E0+33; busy high for 33 cycles.
- Priority in IDLE: start > mthi/mtlo. Same-cycle mthi/mtlo alongside start is ignored.
- mthi and mtlo together: both registers take wr_data.
- start, mthi and mtlo while busy: ignored; no queueing. The hazard unit must not issue them.
- cancel=1 while busy: return to IDLE next edge, hi/lo unchanged, no done.
- cancel in IDLE: no effect; it does not block a same-cycle start.
- Divide by zero (B=0): full latency, no sign fix. Result lo=32'hFFFFFFFF, hi=A (original rs_data bits).
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap), no exception.
- Operands are captured at start. Changes to rs_data/rt_data afterwards have no effect.

Decomposition:
- Shared package (mips_pkg) holds:
  - OP_MULT/OP_MULTU/OP_DIV/OP_DIVU encodings.
  - State encodings IDLE/RUN/FIX.
  - WORD_W=32.
- One natural sub-module: md_datapath_step, the combinational single-iteration shift-add / shift-subtract.
- The FSM, counter, sign fix-up and HI/LO registers stay in mult_div_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 34 edges: hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy low afterwards.
- MULT -3 x 7 (0xFFFFFFFD, 0x00000007) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xAAAA0000 then MTLO 0x5555 in IDLE; start MULTU 5x5; cancel at cycle 10; then rst at cycle 12 of a second op:
  - after cancel: hi/lo stay 0xAAAA0000/0x5555, no done;
  - after rst: hi=lo=0, busy=0.
- start and mthi in the same IDLE cycle, then mtlo and start asserted while busy -> mthi ignored, mid-op requests ignored, final result equals the first op's result.
